// File: rtl/transform_line_receiver.sv
// Receives paired {lhs,rhs} ASCII characters one pair per handshake, stores one
// terminated line in a word buffer and reports length, per-lane XOR and errors.
module transform_line_receiver #(
   parameter int         DEPTH   = 64,
   parameter int         AW      = 6,
   parameter logic [7:0] TERM    = 8'h00,
   parameter int         TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    lhs_in,
   input  logic [7:0]    rhs_in,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data,
   output logic          busy,
   output logic          line_done,
   output logic [AW:0]   line_len,
   output logic [7:0]    lhs_xor,
   output logic [7:0]    rhs_xor,
   output logic          err_overflow,
   output logic          err_timeout,
   output logic [1:0]    state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_nextState;

   logic [15:0]   r_mem [DEPTH];
   logic [AW:0]   r_lineLen;
   logic [7:0]    r_lhsXor;
   logic [7:0]    r_rhsXor;
   logic          r_errOverflow;
   logic          r_errTimeout;
   logic          r_lineDone;
   logic [CW-1:0] r_idleCnt;
   logic [15:0]   r_rdData;

   logic          w_recv;
   logic          w_xfer;
   logic          w_isTerm;
   logic          w_full;
   logic          w_idleLimit;
   logic          w_clear;
   logic          w_store;
   logic          w_setDone;
   logic          w_setOverflow;
   logic          w_setTimeout;

   assign w_recv      = (r_state == RECV);
   assign w_xfer      = in_valid & w_recv;
   assign w_isTerm    = (lhs_in == TERM) && (rhs_in == TERM);
   assign w_full      = (r_lineLen == (AW + 1)'(DEPTH));
   assign w_idleLimit = (r_idleCnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A terminator beat outranks the full check, so a line of exactly DEPTH
   // pairs still completes normally.
   always_comb begin
      w_nextState   = r_state;
      w_clear       = 1'b0;
      w_store       = 1'b0;
      w_setDone     = 1'b0;
      w_setOverflow = 1'b0;
      w_setTimeout  = 1'b0;
      case (r_state)
         IDLE, DONE, ERR: begin
            if (arm) begin
               w_nextState = RECV;
               w_clear     = 1'b1;
            end
         end
         RECV: begin
            if (w_xfer) begin
               if (w_isTerm) begin
                  w_nextState = DONE;
                  w_setDone   = 1'b1;
               end else if (w_full) begin
                  w_nextState   = ERR;
                  w_setOverflow = 1'b1;
               end else begin
                  w_store = 1'b1;
               end
            end else if (w_idleLimit) begin
               w_nextState  = ERR;
               w_setTimeout = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lineLen     <= '0;
         r_lhsXor      <= '0;
         r_rhsXor      <= '0;
         r_errOverflow <= 1'b0;
         r_errTimeout  <= 1'b0;
         r_lineDone    <= 1'b0;
         r_idleCnt     <= '0;
      end else begin
         r_lineDone <= w_setDone;
         if (w_clear) begin
            r_lineLen     <= '0;
            r_lhsXor      <= '0;
            r_rhsXor      <= '0;
            r_errOverflow <= 1'b0;
            r_errTimeout  <= 1'b0;
            r_idleCnt     <= '0;
         end else begin
            if (w_store) begin
               r_lineLen <= r_lineLen + 1'b1;
               r_lhsXor  <= r_lhsXor ^ lhs_in;
               r_rhsXor  <= r_rhsXor ^ rhs_in;
            end
            if (w_setOverflow) begin
               r_errOverflow <= 1'b1;
            end
            if (w_setTimeout) begin
               r_errTimeout <= 1'b1;
            end
            if (w_recv) begin
               r_idleCnt <= w_xfer ? '0 : r_idleCnt + 1'b1;
            end
         end
      end
   end

   // Buffer contents are deliberately left unreset; line_len gates visibility.
   always_ff @(posedge clk) begin
      if (w_store && !rst) begin
         r_mem[r_lineLen[AW-1:0]] <= {lhs_in, rhs_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdData <= '0;
      end else if ({1'b0, rd_addr} < r_lineLen) begin
         r_rdData <= r_mem[rd_addr];
      end else begin
         r_rdData <= '0;
      end
   end

   assign in_ready     = w_recv;
   assign busy         = w_recv;
   assign line_done    = r_lineDone;
   assign line_len     = r_lineLen;
   assign lhs_xor      = r_lhsXor;
   assign rhs_xor      = r_rhsXor;
   assign err_overflow = r_errOverflow;
   assign err_timeout  = r_errTimeout;
   assign rd_data      = r_rdData;
   assign state        = r_state;

endmodule
